// File: rtl/rr_stream_arbiter_pkg.sv
// Shared state encodings and index-width helper for the stream arbiter family.
// No logic; compile-time definitions only.
package rr_stream_arbiter_pkg;

  typedef enum logic {
    ST_ARB  = 1'b0,
    ST_HOLD = 1'b1
  } state_t;

  function automatic int clog2_min1(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Rotating-priority encoder: first set request strictly after i_ptr, wrapping modulo WIDTH.
// Purely combinational; zero latency, no backpressure of its own.
module rr_pick
  import rr_stream_arbiter_pkg::*;
#(
  parameter int WIDTH = 8,
  localparam int IW   = clog2_min1(WIDTH)
) (
  input  logic [WIDTH-1:0] i_req,
  input  logic [IW-1:0]    i_ptr,
  output logic [WIDTH-1:0] o_grant,
  output logic [IW-1:0]    o_idx,
  output logic             o_vld
);

  logic [WIDTH-1:0] w_hi;

  always_comb begin
    w_hi = '0;
    for (int c = 0; c < WIDTH; c++) begin
      w_hi[c] = i_req[c] && (c > int'(i_ptr));
    end
  end

  // Lowest request above the pointer wins; otherwise wrap to the lowest request overall.
  always_comb begin
    o_idx   = '0;
    o_vld   = 1'b0;
    o_grant = '0;
    for (int c = WIDTH - 1; c >= 0; c--) begin
      if (i_req[c]) begin
        o_idx = IW'(c);
        o_vld = 1'b1;
      end
    end
    for (int c = WIDTH - 1; c >= 0; c--) begin
      if (w_hi[c]) begin
        o_idx = IW'(c);
      end
    end
    for (int c = 0; c < WIDTH; c++) begin
      o_grant[c] = o_vld && (o_idx == IW'(c));
    end
  end

endmodule

// File: rtl/rr_stream_arbiter.sv
// N-channel round-robin merge of FWFT sources with bounded hold; grant is combinational,
// DATA_OUT/CH_ID/WRITE_OUT follow 1 cycle later; READY_OUT=0 suppresses all grants.
module rr_stream_arbiter
  import rr_stream_arbiter_pkg::*;
#(
  parameter int WIDTH      = 8,
  parameter int DATA_WIDTH = 32,
  parameter int MAX_HOLD   = 256,
  parameter int CNT_WIDTH  = 16,
  localparam int CIW       = clog2_min1(WIDTH),
  localparam int HCW       = clog2_min1(MAX_HOLD + 1)
) (
  input  logic                        CLK,
  input  logic                        RST_N,
  input  logic [WIDTH-1:0]            CH_ENABLE,
  input  logic [WIDTH-1:0]            WRITE_REQ,
  input  logic [WIDTH-1:0]            HOLD_REQ,
  input  logic [WIDTH*DATA_WIDTH-1:0] DATA_IN,
  output logic [WIDTH-1:0]            READ_GRANT,
  input  logic                        READY_OUT,
  output logic                        WRITE_OUT,
  output logic [DATA_WIDTH-1:0]       DATA_OUT,
  output logic [CIW-1:0]              CH_ID,
  output logic                        HOLD_TIMEOUT,
  input  logic                        CNT_CLEAR,
  output logic [WIDTH*CNT_WIDTH-1:0]  WORD_CNT
);

  state_t                r_state;
  logic [CIW-1:0]        r_ptr;
  logic [CIW-1:0]        r_hold_ch;
  logic [HCW-1:0]        r_hold_cnt;
  logic [WIDTH-1:0]      r_blocked;
  logic                  r_write;
  logic [DATA_WIDTH-1:0] r_data;
  logic [CIW-1:0]        r_ch_id;
  logic                  r_timeout;
  logic [CNT_WIDTH-1:0]  r_cnt [WIDTH];

  logic [WIDTH-1:0]      w_elig;
  logic [WIDTH-1:0]      w_hold_oh;
  logic [WIDTH-1:0]      w_req;
  logic [WIDTH-1:0]      w_grant;
  logic [CIW-1:0]        w_idx;
  logic                  w_vld;
  logic                  w_hold_keep;
  logic                  w_hold_last;
  logic                  w_enter;
  logic                  w_enter_last;
  logic [WIDTH-1:0]      w_blk_set;
  logic [DATA_WIDTH-1:0] w_data;

  assign w_elig = WRITE_REQ & CH_ENABLE;

  always_comb begin
    w_hold_oh = '0;
    for (int c = 0; c < WIDTH; c++) begin
      w_hold_oh[c] = (r_hold_ch == CIW'(c));
    end
  end

  // A release (HOLD_REQ or enable dropped) takes effect in the same cycle: normal arbitration resumes.
  assign w_hold_keep = (r_state == ST_HOLD) && (|(w_hold_oh & HOLD_REQ & CH_ENABLE));
  assign w_req = (!RST_N || !READY_OUT) ? '0
               : (w_hold_keep ? (w_elig & w_hold_oh) : w_elig);

  rr_pick #(
    .WIDTH (WIDTH)
  ) u_pick (
    .i_req   (w_req),
    .i_ptr   (r_ptr),
    .o_grant (w_grant),
    .o_idx   (w_idx),
    .o_vld   (w_vld)
  );

  assign READ_GRANT = w_grant;

  always_comb begin
    w_data = '0;
    for (int c = 0; c < WIDTH; c++) begin
      if (w_grant[c]) begin
        w_data = DATA_IN[c*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  assign w_hold_last  = w_hold_keep && w_vld && (r_hold_cnt >= HCW'(MAX_HOLD - 1));
  assign w_enter      = !w_hold_keep && w_vld && (|(w_grant & HOLD_REQ & ~r_blocked));
  assign w_enter_last = w_enter && (MAX_HOLD <= 1);
  assign w_blk_set    = w_hold_last ? w_hold_oh : (w_enter_last ? w_grant : '0);

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_state    <= ST_ARB;
      r_ptr      <= CIW'(WIDTH - 1);
      r_hold_ch  <= '0;
      r_hold_cnt <= '0;
      r_blocked  <= '0;
      r_write    <= 1'b0;
      r_data     <= '0;
      r_ch_id    <= '0;
      r_timeout  <= 1'b0;
    end else begin
      r_write   <= w_vld;
      r_timeout <= w_hold_last || w_enter_last;
      r_blocked <= (r_blocked | w_blk_set) & HOLD_REQ;
      if (w_vld) begin
        r_data  <= w_data;
        r_ch_id <= w_idx;
        r_ptr   <= w_idx;
      end
      if (w_hold_keep) begin
        if (w_hold_last) begin
          r_state    <= ST_ARB;
          r_hold_cnt <= '0;
        end else if (w_vld) begin
          r_hold_cnt <= r_hold_cnt + 1'b1;
        end
      end else if (w_enter && !w_enter_last) begin
        r_state    <= ST_HOLD;
        r_hold_ch  <= w_idx;
        r_hold_cnt <= HCW'(1);
      end else begin
        r_state    <= ST_ARB;
        r_hold_cnt <= '0;
      end
    end
  end

  for (genvar g = 0; g < WIDTH; g++) begin : g_cnt
    always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
        r_cnt[g] <= '0;
      end else if (CNT_CLEAR) begin
        r_cnt[g] <= '0;
      end else if (w_grant[g] && (r_cnt[g] != '1)) begin
        r_cnt[g] <= r_cnt[g] + 1'b1;
      end
    end
    assign WORD_CNT[g*CNT_WIDTH +: CNT_WIDTH] = r_cnt[g];
  end

  assign WRITE_OUT    = r_write;
  assign DATA_OUT     = r_data;
  assign CH_ID        = r_ch_id;
  assign HOLD_TIMEOUT = r_timeout;

endmodule

// File: tb/tb_rr_stream_arbiter.sv
// Directed bench for rr_stream_arbiter (WIDTH=8, MAX_HOLD=4, CNT_WIDTH=4).
module tb_rr_stream_arbiter;

  localparam int W  = 8;
  localparam int DW = 32;
  localparam int MH = 4;
  localparam int CW = 4;

  logic            clk;
  logic            rst_n;
  logic [W-1:0]    ch_enable;
  logic [W-1:0]    write_req;
  logic [W-1:0]    hold_req;
  logic [W*DW-1:0] data_in;
  logic [W-1:0]    read_grant;
  logic            ready_out;
  logic            write_out;
  logic [DW-1:0]   data_out;
  logic [2:0]      ch_id;
  logic            hold_timeout;
  logic            cnt_clear;
  logic [W*CW-1:0] word_cnt;

  int n_run  = 0;
  int n_fail = 0;

  rr_stream_arbiter #(
    .WIDTH      (W),
    .DATA_WIDTH (DW),
    .MAX_HOLD   (MH),
    .CNT_WIDTH  (CW)
  ) dut (
    .CLK          (clk),
    .RST_N        (rst_n),
    .CH_ENABLE    (ch_enable),
    .WRITE_REQ    (write_req),
    .HOLD_REQ     (hold_req),
    .DATA_IN      (data_in),
    .READ_GRANT   (read_grant),
    .READY_OUT    (ready_out),
    .WRITE_OUT    (write_out),
    .DATA_OUT     (data_out),
    .CH_ID        (ch_id),
    .HOLD_TIMEOUT (hold_timeout),
    .CNT_CLEAR    (cnt_clear),
    .WORD_CNT     (word_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // One clock cycle with inputs already applied: grant checked mid-cycle, registered outputs after the edge.
  task automatic cyc(input string tag, input logic [7:0] eg, input logic ew,
                     input logic [2:0] eid, input logic eto);
    #1;
    check({tag, "/grant"}, 64'(read_grant), 64'(eg));
    @(posedge clk);
    #1;
    check({tag, "/wr"}, 64'(write_out), 64'(ew));
    if (ew) begin
      check({tag, "/id"}, 64'(ch_id), 64'(eid));
      check({tag, "/data"}, 64'(data_out), 64'(32'hC0DE_0000 + 32'(eid)));
    end
    check({tag, "/to"}, 64'(hold_timeout), 64'(eto));
  endtask

  function automatic logic [3:0] cnt_of(input int c);
    return word_cnt[c*CW +: CW];
  endfunction

  initial begin
    for (int c = 0; c < W; c++) data_in[c*DW +: DW] = 32'hC0DE_0000 + 32'(c);
    rst_n = 1'b0; ch_enable = 8'hFF; write_req = '0; hold_req = '0;
    ready_out = 1'b0; cnt_clear = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst/wr", 64'(write_out), 64'd0);
    check("rst/data", 64'(data_out), 64'd0);
    check("rst/id", 64'(ch_id), 64'd0);
    check("rst/to", 64'(hold_timeout), 64'd0);
    check("rst/cnt", 64'(word_cnt), 64'd0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Round-robin over all channels, starting at channel 0.
    write_req = 8'hFF; ready_out = 1'b1;
    for (int k = 0; k < 9; k++) cyc("rr", 8'(1 << (k % 8)), 1'b1, 3'(k % 8), 1'b0);

    // Backpressure: ch1, ch2, three stalled cycles, then ch3, ch4.
    cyc("bp_a", 8'h02, 1'b1, 3'd1, 1'b0);
    cyc("bp_b", 8'h04, 1'b1, 3'd2, 1'b0);
    ready_out = 1'b0;
    for (int k = 0; k < 3; k++) cyc("bp_stall", 8'h00, 1'b0, 3'd0, 1'b0);
    ready_out = 1'b1;
    cyc("bp_c", 8'h08, 1'b1, 3'd3, 1'b0);
    cyc("bp_d", 8'h10, 1'b1, 3'd4, 1'b0);
    check("cnt_rr0", 64'(cnt_of(0)), 64'd2);
    check("cnt_rr3", 64'(cnt_of(3)), 64'd2);
    check("cnt_rr7", 64'(cnt_of(7)), 64'd1);

    // Hold: ch2 keeps the grant over ch5, including a two-cycle gap.
    write_req = 8'h00; cnt_clear = 1'b1;
    cyc("idle", 8'h00, 1'b0, 3'd0, 1'b0);
    cnt_clear = 1'b0;
    hold_req = 8'h04; write_req = 8'h04;
    cyc("hold_enter", 8'h04, 1'b1, 3'd2, 1'b0);
    write_req = 8'h24;
    cyc("hold_2", 8'h04, 1'b1, 3'd2, 1'b0);
    write_req = 8'h20;
    cyc("hold_gap1", 8'h00, 1'b0, 3'd0, 1'b0);
    cyc("hold_gap2", 8'h00, 1'b0, 3'd0, 1'b0);
    write_req = 8'h24;
    cyc("hold_3", 8'h04, 1'b1, 3'd2, 1'b0);
    hold_req = 8'h00;
    cyc("hold_rel", 8'h20, 1'b1, 3'd5, 1'b0);

    // Timeout: ch1 holds for four words, then ch3; ch1 blocked until HOLD_REQ toggles.
    hold_req = 8'h02; write_req = 8'h0A;
    cyc("to_1", 8'h02, 1'b1, 3'd1, 1'b0);
    cyc("to_2", 8'h02, 1'b1, 3'd1, 1'b0);
    cyc("to_3", 8'h02, 1'b1, 3'd1, 1'b0);
    cyc("to_4", 8'h02, 1'b1, 3'd1, 1'b1);
    cyc("to_ch3", 8'h08, 1'b1, 3'd3, 1'b0);
    cyc("blk_ch1", 8'h02, 1'b1, 3'd1, 1'b0);
    cyc("blk_ch3", 8'h08, 1'b1, 3'd3, 1'b0);
    hold_req = 8'h00;
    cyc("tog_ch1", 8'h02, 1'b1, 3'd1, 1'b0);
    hold_req = 8'h02;
    cyc("tog_ch3", 8'h08, 1'b1, 3'd3, 1'b0);
    cyc("rehold_1", 8'h02, 1'b1, 3'd1, 1'b0);
    cyc("rehold_2", 8'h02, 1'b1, 3'd1, 1'b0);
    hold_req = 8'h00;
    cyc("rehold_rel", 8'h08, 1'b1, 3'd3, 1'b0);

    // Enable mask and word counters.
    write_req = 8'h00; cnt_clear = 1'b1;
    cyc("clr", 8'h00, 1'b0, 3'd0, 1'b0);
    cnt_clear = 1'b0;
    ch_enable = 8'hFE; write_req = 8'h01;
    for (int k = 0; k < 3; k++) cyc("dis_ch0", 8'h00, 1'b0, 3'd0, 1'b0);
    check("cnt_dis0", 64'(cnt_of(0)), 64'd0);
    ch_enable = 8'hFF; write_req = 8'h40;
    for (int k = 0; k < 10; k++) cyc("ch6", 8'h40, 1'b1, 3'd6, 1'b0);
    check("cnt6_10", 64'(cnt_of(6)), 64'd10);
    for (int k = 0; k < 10; k++) cyc("ch6", 8'h40, 1'b1, 3'd6, 1'b0);
    check("cnt6_sat", 64'(cnt_of(6)), 64'd15);
    cnt_clear = 1'b1;
    cyc("clr_grant", 8'h40, 1'b1, 3'd6, 1'b0);
    check("cnt6_clr", 64'(cnt_of(6)), 64'd0);
    cnt_clear = 1'b0;
    cyc("after_clr", 8'h40, 1'b1, 3'd6, 1'b0);
    check("cnt6_one", 64'(cnt_of(6)), 64'd1);

    // Asynchronous reset in the middle of a hold.
    hold_req = 8'h08; write_req = 8'h18;
    cyc("ar_hold1", 8'h08, 1'b1, 3'd3, 1'b0);
    cyc("ar_hold2", 8'h08, 1'b1, 3'd3, 1'b0);
    check("ar_cnt3", 64'(cnt_of(3)), 64'd2);
    #2;
    rst_n = 1'b0;
    #1;
    check("ar/wr", 64'(write_out), 64'd0);
    check("ar/data", 64'(data_out), 64'd0);
    check("ar/id", 64'(ch_id), 64'd0);
    check("ar/to", 64'(hold_timeout), 64'd0);
    check("ar/cnt", 64'(word_cnt), 64'd0);
    check("ar/grant", 64'(read_grant), 64'd0);
    rst_n = 1'b1; hold_req = 8'h00; write_req = 8'hFF;
    cyc("ar_first", 8'h01, 1'b1, 3'd0, 1'b0);
    cyc("ar_second", 8'h02, 1'b1, 3'd1, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
